// File: rtl/fetch_ctrl.sv
// Program-counter sequencer: IDLE/RUN/DONE control with conditional absolute (LUT)
// and relative jumps, stall hold, halt detection and a saturating run-cycle counter.
module fetch_ctrl #(
    parameter int unsigned D         = 12,
    parameter int unsigned LW        = 2,
    parameter int unsigned HALT_ADDR = 128,
    parameter int unsigned CW        = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          stall,
    input  logic          absjump_en,
    input  logic          reljump_en,
    input  logic [LW-1:0] lut_sel,
    input  logic [D-1:0]  rel_off,
    input  logic [1:0]    br_cond,
    input  logic          zeroQ,
    input  logic          pariQ,
    input  logic          lut_we,
    input  logic [LW-1:0] lut_waddr,
    input  logic [D-1:0]  lut_wdata,
    output logic [D-1:0]  prog_ctr,
    output logic          busy,
    output logic          done,
    output logic          jump_taken,
    output logic [CW-1:0] cycle_cnt
);

    localparam int unsigned LUT_N   = 1 << LW;
    localparam logic [63:0] PC_SPAN = 64'(1) << D;
    // A halt address outside the PC range can never be reached.
    localparam logic        HALT_EN = 64'(HALT_ADDR) < PC_SPAN;
    localparam logic [D-1:0] HALT_PC = D'(HALT_ADDR);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [D-1:0]  r_pc;
    logic          r_busy;
    logic          r_done;
    logic          r_jt;
    logic [CW-1:0] r_cnt;
    logic [D-1:0]  r_lut [LUT_N];

    logic          w_cond;
    logic          w_at_halt;

    assign prog_ctr   = r_pc;
    assign busy       = r_busy;
    assign done       = r_done;
    assign jump_taken = r_jt;
    assign cycle_cnt  = r_cnt;

    assign w_at_halt = HALT_EN && (r_pc == HALT_PC);

    // Branch condition select from registered ALU flags.
    always_comb begin
        w_cond = 1'b1;
        case (br_cond)
            2'b00:   w_cond = 1'b1;
            2'b01:   w_cond = zeroQ;
            2'b10:   w_cond = ~zeroQ;
            default: w_cond = pariQ;
        endcase
    end

    // Jump LUT; a same-edge read sees the pre-write contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(LUT_N); i++) begin
                r_lut[i] <= '0;
            end
        end else if (lut_we) begin
            r_lut[lut_waddr] <= lut_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_jt    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_jt <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_pc <= '0;
                    if (req) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    if (r_cnt != '1) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                    if (w_at_halt) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (!stall) begin
                        if (absjump_en && w_cond) begin
                            r_pc <= r_lut[lut_sel];
                            r_jt <= 1'b1;
                        end else if (reljump_en && w_cond) begin
                            r_pc <= r_pc + rel_off;
                            r_jt <= 1'b1;
                        end else begin
                            r_pc <= r_pc + D'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (!req) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                        r_pc    <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter D, default 12: program-counter width in bits.
REQ-002 Parameter LW, default 2: jump-LUT address width; LUT holds 2**LW entries of D bits.
REQ-003 Parameter HALT_ADDR, default 128: PC value that ends a run.
REQ-004 Parameter CW, default 16: cycle-counter width.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 req  in  1  start request, level-sampled.
REQ-008 stall  in  1  hold PC this cycle.
REQ-009 absjump_en  in  1  absolute jump to LUT entry.
REQ-010 reljump_en  in  1  relative jump by rel_off.
REQ-011 lut_sel  in  LW  LUT entry for absolute jump.
REQ-012 rel_off  in  D  two's-complement PC offset.
REQ-013 br_cond  in  2  condition: 00 always, 01 zeroQ=1, 10 zeroQ=0, 11 pariQ=1.
REQ-014 zeroQ, pariQ  in  1 each  registered ALU flags.
REQ-015 lut_we  in  1  LUT write enable.
REQ-016 lut_waddr  in  LW  LUT write address.
REQ-017 lut_wdata  in  D  LUT write data.
REQ-018 prog_ctr  out  D  current PC.
REQ-019 busy  out  1  high in RUN.
REQ-020 done  out  1  high in DONE.
REQ-021 jump_taken  out  1  registered; high for one cycle after any taken jump.
REQ-022 cycle_cnt  out  CW  RUN cycles elapsed, stalls included.

Function
REQ-023 FSM states IDLE, RUN, DONE; busy=(RUN), done=(DONE), both registered-state decodes.
REQ-024 IDLE: prog_ctr held at 0; req=1 -> RUN next edge, prog_ctr=0, cycle_cnt cleared to 0.
REQ-025 RUN, per edge, priority: (a) prog_ctr==HALT_ADDR -> DONE, PC frozen; (b) stall=1 -> PC held; (c) absjump_en and cond true -> prog_ctr=LUT[lut_sel]; (d) reljump_en and cond true -> prog_ctr=prog_ctr+rel_off mod 2**D; (e) else prog_ctr+1 mod 2**D.
REQ-026 Jump with cond false falls to (e); absjump_en and reljump_en both set -> absolute wins.
REQ-027 jump_taken=1 on cycle after edge where (c) or (d) applied, else 0; 0 under stall or halt.
REQ-028 cycle_cnt increments every RUN edge, including stalled edges and the halt edge; saturates at 2**CW-1.
REQ-029 req ignored in RUN; a run cannot be restarted before DONE.
REQ-030 DONE: prog_ctr, cycle_cnt held; req=0 -> IDLE next edge (prog_ctr to 0); req=1 keeps DONE.
REQ-031 PC wrap: prog_ctr=2**D-1 with (e) -> 0; negative rel_off wraps modulo 2**D.
REQ-032 LUT writable in any state; same-cycle write and jump read of same entry uses old value; new value visible next cycle.
REQ-033 Halt check uses registered prog_ctr only; a jump landing on HALT_ADDR halts one edge later.
REQ-034 HALT_ADDR>=2**D -> never halts; run ends only by reset.

Reset
REQ-035 reset=0 forces immediately, independent of clk: state IDLE, prog_ctr=0, busy=0, done=0, jump_taken=0, cycle_cnt=0, all LUT entries 0.
REQ-036 Reset mid-RUN aborts run with no further PC update; release needs a new req to start.

Verification
REQ-037 reset pulse mid-RUN at PC=37 -> all outputs 0 within same cycle, state IDLE after release.
REQ-038 req=1, no jumps/stalls -> prog_ctr 0..128, done=1 on edge after PC=128, cycle_cnt=129.
REQ-039 LUT[2]=0x050 written, absjump_en=1, lut_sel=2, br_cond=00 at PC=5 -> PC=0x050, jump_taken=1 one cycle.
REQ-040 reljump_en=1, rel_off=-3, br_cond=01 with zeroQ=0 then zeroQ=1 at PC=10 -> PC=11 then PC=8 next jump.
REQ-041 stall=1 three cycles at PC=20 -> PC holds 20, cycle_cnt advances by 3; both jump enables set -> absolute taken.
REQ-042 D=4, HALT_ADDR=16 -> PC wraps 15->0; same-cycle lut_we and jump to that entry -> old value used.
